// File: rtl/serial_pattern_detector.sv
// rtl/serial_pattern_detector.sv - overlapping N-bit serial pattern detector with saturating hit count
module serial_pattern_detector #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int             CW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          din,
    input  logic          din_valid,
    input  logic          clear,
    output logic          match,
    output logic [N-1:0]  hist,
    output logic          primed,
    output logic [CW-1:0] count
);
    localparam int            FW   = $clog2(N + 1);
    localparam logic [FW-1:0] FULL = FW'(N);

    logic [FW-1:0] fill;
    logic [FW-1:0] fill_next;
    logic [N-1:0]  shifted;
    logic          hit;

    // fill gates detection so the zeroed reset history can never look like a pattern
    always_comb begin
        shifted   = {hist[N-2:0], din};
        fill_next = (fill == FULL) ? FULL : fill + FW'(1);
        hit       = din_valid && (shifted == PATTERN) && (fill_next == FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
            count <= '0;
        end else begin
            match <= hit;
            if (din_valid) begin
                hist <= shifted;
                fill <= fill_next;
            end
            if (clear) begin
                count <= '0;
            end else if (hit && (count != '1)) begin
                count <= count + CW'(1);
            end
        end
    end

    assign primed = (fill == FULL);

endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb/tb_serial_pattern_detector.sv - scoreboard bench for serial_pattern_detector
module tb_serial_pattern_detector;
    logic       clk;
    logic       reset;
    logic       a_din, a_valid, a_clear;
    logic       b_din, b_valid, b_clear;
    logic       a_match, a_primed;
    logic       b_match, b_primed;
    logic [3:0] a_hist, b_hist;
    logic [7:0] a_count;
    logic [1:0] b_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         sel;
        bit         m;
        logic [3:0] h;
        bit         p;
        int         c;
    } exp_t;

    exp_t sb[$];

    serial_pattern_detector dut_a (
        .clk(clk), .reset(reset), .din(a_din), .din_valid(a_valid), .clear(a_clear),
        .match(a_match), .hist(a_hist), .primed(a_primed), .count(a_count)
    );

    serial_pattern_detector #(.N(4), .PATTERN(4'b0000), .CW(2)) dut_b (
        .clk(clk), .reset(reset), .din(b_din), .din_valid(b_valid), .clear(b_clear),
        .match(b_match), .hist(b_hist), .primed(b_primed), .count(b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per clocked step, sampled on the falling edge
    always begin
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.sel) begin
                cmp("a_match", int'(a_match), int'(e.m));
                cmp("a_hist", int'(a_hist), int'(e.h));
                cmp("a_primed", int'(a_primed), int'(e.p));
                cmp("a_count", int'(a_count), e.c);
            end else begin
                cmp("b_match", int'(b_match), int'(e.m));
                cmp("b_hist", int'(b_hist), int'(e.h));
                cmp("b_primed", int'(b_primed), int'(e.p));
                cmp("b_count", int'(b_count), e.c);
            end
        end
    end

    // Called just after a falling edge; drives one clock's worth of inputs
    task automatic step(input bit sel, input bit v, input bit d, input bit clr,
                        input bit m, input logic [3:0] h, input bit p, input int c);
        exp_t e;
        a_valid = !sel && v;
        a_din   = d;
        a_clear = !sel && clr;
        b_valid = sel && v;
        b_din   = d;
        b_clear = sel && clr;
        e.sel = sel; e.m = m; e.h = h; e.p = p; e.c = c;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_a_match"}, int'(a_match), 0);
        cmp({tag, "_a_count"}, int'(a_count), 0);
        cmp({tag, "_a_hist"}, int'(a_hist), 0);
        cmp({tag, "_a_primed"}, int'(a_primed), 0);
        cmp({tag, "_b_count"}, int'(b_count), 0);
        cmp({tag, "_b_hist"}, int'(b_hist), 0);
    endtask

    // Asynchronous pulse entirely between clock edges
    task automatic pulse_reset(input string tag, input bit chk);
        a_valid = 1'b0; b_valid = 1'b0; a_clear = 1'b0; b_clear = 1'b0;
        reset = 1'b0;
        #1;
        if (chk) check_zero(tag);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int budget;
        reset = 1'b0;
        a_din = 1'b0; a_valid = 1'b0; a_clear = 1'b0;
        b_din = 1'b0; b_valid = 1'b0; b_clear = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        #1;
        reset = 1'b1;

        // Basic detection of 1011
        step(0, 1, 1, 0, 0, 4'b0001, 0, 0);
        step(0, 1, 0, 0, 0, 4'b0010, 0, 0);
        step(0, 1, 1, 0, 0, 4'b0101, 0, 0);
        step(0, 1, 1, 0, 1, 4'b1011, 1, 1);

        // Overlap: 1011011 matches twice
        pulse_reset("r2", 0);
        step(0, 1, 1, 0, 0, 4'b0001, 0, 0);
        step(0, 1, 0, 0, 0, 4'b0010, 0, 0);
        step(0, 1, 1, 0, 0, 4'b0101, 0, 0);
        step(0, 1, 1, 0, 1, 4'b1011, 1, 1);
        step(0, 1, 0, 0, 0, 4'b0110, 1, 1);
        step(0, 1, 1, 0, 0, 4'b1101, 1, 1);
        step(0, 1, 1, 0, 1, 4'b1011, 1, 2);

        // Valid gaps; din toggles while idle and must be ignored
        pulse_reset("r3", 0);
        step(0, 1, 1, 0, 0, 4'b0001, 0, 0);
        step(0, 0, 0, 0, 0, 4'b0001, 0, 0);
        step(0, 0, 1, 0, 0, 4'b0001, 0, 0);
        step(0, 1, 0, 0, 0, 4'b0010, 0, 0);
        step(0, 0, 1, 0, 0, 4'b0010, 0, 0);
        step(0, 0, 1, 0, 0, 4'b0010, 0, 0);
        step(0, 0, 0, 0, 0, 4'b0010, 0, 0);
        step(0, 1, 1, 0, 0, 4'b0101, 0, 0);
        step(0, 1, 1, 0, 1, 4'b1011, 1, 1);

        // Reset mid-pattern (also clears the count of 1 left above)
        pulse_reset("r4a", 0);
        step(0, 1, 1, 0, 0, 4'b0001, 0, 0);
        step(0, 1, 0, 0, 0, 4'b0010, 0, 0);
        step(0, 1, 1, 0, 0, 4'b0101, 0, 0);
        step(0, 1, 1, 0, 1, 4'b1011, 1, 1);
        step(0, 1, 0, 0, 0, 4'b0110, 1, 1);
        step(0, 1, 1, 0, 0, 4'b1101, 1, 1);
        pulse_reset("midreset", 1);
        step(0, 1, 1, 0, 0, 4'b0001, 0, 0);
        step(0, 1, 1, 0, 0, 4'b0011, 0, 0);
        step(0, 1, 0, 0, 0, 4'b0110, 0, 0);
        step(0, 1, 1, 0, 0, 4'b1101, 1, 0);
        step(0, 1, 1, 0, 1, 4'b1011, 1, 1);

        // PATTERN=0000, CW=2: priming guard and saturation at 3
        pulse_reset("r5", 0);
        step(1, 1, 0, 0, 0, 4'b0000, 0, 0);
        step(1, 1, 0, 0, 0, 4'b0000, 0, 0);
        step(1, 1, 0, 0, 0, 4'b0000, 0, 0);
        step(1, 1, 0, 0, 1, 4'b0000, 1, 1);
        step(1, 1, 0, 0, 1, 4'b0000, 1, 2);
        step(1, 1, 0, 0, 1, 4'b0000, 1, 3);
        step(1, 1, 0, 0, 1, 4'b0000, 1, 3);

        // Clear wins over a simultaneous match increment
        step(1, 1, 0, 1, 1, 4'b0000, 1, 0);
        step(1, 1, 0, 0, 1, 4'b0000, 1, 1);
        step(1, 0, 1, 1, 0, 4'b0000, 1, 0);
        step(1, 1, 1, 0, 0, 4'b0001, 1, 0);

        a_valid = 1'b0; b_valid = 1'b0; a_clear = 1'b0; b_clear = 1'b0;
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        #1;
        cmp("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_pattern_detector.md
# serial_pattern_detector

Downstream consumer of the asynchronous-reset D flip-flop stage. It samples the registered serial bit stream (the flip-flop's Q) and detects a fixed N-bit pattern, with overlapping matches allowed. For each detection it raises a one-cycle match pulse and increments a saturating detection counter. The last N accepted bits are exposed for debug.

## Interface
- N, default 4: pattern length in bits, range 2..16
- PATTERN, default 4'b1011: pattern to detect, N bits wide, MSB is the oldest bit
- CW, default 8: width of the detection counter
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low: reset=0 forces every register to its reset value immediately, with no clock edge needed
- din  input  1  serial data bit, driven by the upstream flip-flop Q
- din_valid  input  1  din is accepted on a rising edge only when this is 1
- clear  input  1  synchronous clear of count
- match  output  1  registered one-cycle pulse marking a detection
- hist  output  N  last N accepted bits; hist[0] is the newest
- primed  output  1  1 once at least N bits have been accepted since reset
- count  output  CW  number of detections, saturating

## Operation
- Registers: hist[N-1:0], fill counter (0..N, saturating at N), match, count.
- Reset (reset=0, asynchronous): hist=0, fill=0, primed=0, match=0, count=0. This takes priority over every other input.
- Accept, on a rising edge with din_valid=1:
  - hist <= {hist[N-2:0], din}
  - fill <= min(fill+1, N)
- Detection: match <= 1 on an accepting edge when both hold:
  - the shifted value {hist[N-2:0], din} == PATTERN
  - fill+1 >= N, using the next value of fill
- match <= 0 on every other edge, including any edge with din_valid=0.
- Overlap: no state is flushed after a match, so a suffix that is also a prefix is reused. With PATTERN 1011, the stream 1011011 matches twice.
- primed = (fill == N). It is a combinational decode of the fill register.
- Priming guard: the zeroed reset value of hist never produces a false match. With PATTERN=0, a match requires N real zeros.
- count:
  - On an edge where a match is generated, count <= count+1, unless count is all ones, in which case it holds (saturates).
  - clear=1 sets count <= 0. Clear wins over a simultaneous increment.
  - clear does not affect match, hist or fill.
- Idle edges (din_valid=0) leave hist, fill and count unchanged.
- If reset is asserted mid-pattern, the partial pattern is discarded. After release, a full N fresh bits are required before the next match.

## Timing
- Latency: the bit that completes the pattern is accepted at edge k. match is 1 from just after edge k until edge k+1. count shows the new value after edge k.
- Minimum spacing between match pulses is one cycle, when din_valid=1 continuously and the pattern has a period-1 overlap (e.g. PATTERN all ones).
- din and din_valid must be stable around the rising edge of clk. The upstream stage is registered on the same clk, so no synchroniser is required.
- Reset release is treated as synchronous to clk by the integrator. The first accept can occur on the first rising edge after reset returns to 1.

## Test plan
- Basic detection, defaults: after reset, feed 1,0,1,1 on 4 consecutive valid edges. Required: match=1 only in the cycle after the 4th edge, hist=4'b1011, primed=1, count=1.
- Overlap: feed 1,0,1,1,0,1,1 with valid held high. Required: match pulses after the 4th and 7th edges only, count=2.
- Valid gaps: feed 1, then 2 idle cycles, 0, then 3 idle cycles, 1, 1. Required:
  - hist is unchanged across idle cycles
  - match stays 0 during the gaps
  - exactly one match, after the final 1
  - count=1
- Reset mid-stream: feed 1,0,1, then pull reset low between edges. Required:
  - match, count, hist and primed are 0 immediately, before the next edge
  - after release, feeding 1 gives no match and primed=0
  - the full sequence 1,0,1,1 then gives count=1
- Priming and saturation, using PATTERN=4'b0000 and CW=2:
  - 3 zeros give no match
  - the 4th zero gives a match
  - continuing zeros give a match on every edge, with count stopping at 3
- Clear collision, using PATTERN=4'b0000 and CW=2: assert clear on an edge that also produces a match. Required: count=0 and match=1.
